// File: rtl/ring_injector_pkg.sv
// ring_pkg: shared sizes, token/entry types and cc_id one-hot helper for the ring injector
package ring_pkg;
  localparam int PC_WIDTH = 8;
  localparam int CC_ID_BITS = 2;
  localparam int LATENCY_COUNT_WIDTH = 8;
  localparam int STARVE_LIMIT = 4;
  localparam int NUM_CC = 2 ** CC_ID_BITS;
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  typedef struct packed {
    logic [CC_ID_BITS-1:0] cc_id;
    logic [PC_WIDTH-1:0] pc;
  } token_t;
  typedef struct packed {
    token_t tok;
    logic [LATENCY_COUNT_WIDTH-1:0] lat;
  } entry_t;
  function automatic logic [NUM_CC-1:0] onehot_cc(input logic [CC_ID_BITS-1:0] cc_id);
    return NUM_CC'(1) << cc_id;
  endfunction
endpackage

// File: rtl/ring_injector_if.sv
// channel_iface: valid/ready token channel; master drives valid/data/latency, slave drives ready
interface channel_iface;
  import ring_pkg::*;
  logic valid;
  logic ready;
  token_t data;
  logic [LATENCY_COUNT_WIDTH-1:0] latency;
  modport master(output valid, data, latency, input ready);
  modport slave(input valid, data, latency, output ready);
endinterface

// File: rtl/ring_injector_skid.sv
// ring_skid_buffer: 2-entry FIFO with registered head, occupancy and registered cc_id valid mask
// Ports: push_i/push_data_i store, pop_ready_i pops a valid head, head_o/head_valid_o, occupancy_o, valid_mask_o
module ring_skid_buffer
  import ring_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  entry_t            push_data_i,
  input  logic              pop_ready_i,
  output entry_t            head_o,
  output logic              head_valid_o,
  output logic [1:0]        occupancy_o,
  output logic [NUM_CC-1:0] valid_mask_o
);
  entry_t e0_q, e0_d, e1_q, e1_d;
  logic v0_q, v0_d, v1_q, v1_d;
  logic [NUM_CC-1:0] mask_q, mask_d;
  // Pop shifts first so a same-edge push lands behind whatever remains.
  always_comb begin
    e0_d = e0_q;
    e1_d = e1_q;
    v0_d = v0_q;
    v1_d = v1_q;
    if (v0_q && pop_ready_i) begin
      e0_d = e1_q;
      v0_d = v1_q;
      v1_d = 1'b0;
    end
    if (push_i) begin
      if (v0_d) begin
        e1_d = push_data_i;
        v1_d = 1'b1;
      end else begin
        e0_d = push_data_i;
        v0_d = 1'b1;
      end
    end
    mask_d = ({NUM_CC{v0_d}} & onehot_cc(e0_d.tok.cc_id)) | ({NUM_CC{v1_d}} & onehot_cc(e1_d.tok.cc_id));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q <= '0;
      e1_q <= '0;
      v0_q <= 1'b0;
      v1_q <= 1'b0;
      mask_q <= '0;
    end else begin
      e0_q <= e0_d;
      e1_q <= e1_d;
      v0_q <= v0_d;
      v1_q <= v1_d;
      mask_q <= mask_d;
    end
  end
  assign head_o = e0_q;
  assign head_valid_o = v0_q;
  assign occupancy_o = 2'(v0_q) + 2'(v1_q);
  assign valid_mask_o = mask_q;
endmodule

// File: rtl/ring_injector.sv
// ring_injector: merges recirculating ring tokens with injected threads, drops killed cc_ids, skid-buffers output
// Ports: ring_in (slave channel), ring_out (master channel), inject_valid_i/ready_o/pc_i/cc_id_i,
//        kill_mask_i, elaborating_chars_o, dropped_pulse_o
module ring_injector
  import ring_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  channel_iface.slave           ring_in,
  channel_iface.master          ring_out,
  input  logic                  inject_valid_i,
  output logic                  inject_ready_o,
  input  logic [PC_WIDTH-1:0]   inject_pc_i,
  input  logic [CC_ID_BITS-1:0] inject_cc_id_i,
  input  logic [NUM_CC-1:0]     kill_mask_i,
  output logic [NUM_CC-1:0]     elaborating_chars_o,
  output logic                  dropped_pulse_o
);
  logic [1:0] occ;
  logic killed, slot_free, ring_win, push;
  entry_t push_e, head;
  logic head_v;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic dropped_q;
  // slot_free depends only on registered occupancy, keeping ring_out.ready off every ready path.
  always_comb begin
    killed = ring_in.valid && kill_mask_i[ring_in.data.cc_id];
    slot_free = occ < 2'd2;
    ring_win = ring_in.valid && !killed && starve_q < STARVE_W'(STARVE_LIMIT);
    inject_ready_o = slot_free && inject_valid_i && !ring_win;
    ring_in.ready = killed || (slot_free && ring_win);
    push = (slot_free && ring_win) || inject_ready_o;
    push_e.tok = ring_win ? ring_in.data : {inject_cc_id_i, inject_pc_i};
    push_e.lat = !ring_win ? '0 : (&ring_in.latency ? ring_in.latency : ring_in.latency + LATENCY_COUNT_WIDTH'(1));
    starve_d = (!inject_valid_i || inject_ready_o) ? '0
             : (starve_q == STARVE_W'(STARVE_LIMIT) ? starve_q : starve_q + STARVE_W'(1));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
      dropped_q <= 1'b0;
    end else begin
      starve_q <= starve_d;
      dropped_q <= killed;
    end
  end
  ring_skid_buffer u_skid (
    .clk(clk),
    .rst_n(rst_n),
    .push_i(push),
    .push_data_i(push_e),
    .pop_ready_i(ring_out.ready),
    .head_o(head),
    .head_valid_o(head_v),
    .occupancy_o(occ),
    .valid_mask_o(elaborating_chars_o)
  );
  assign ring_out.valid = head_v;
  assign ring_out.data = head.tok;
  assign ring_out.latency = head.lat;
  assign dropped_pulse_o = dropped_q;
endmodule
